// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs, default widths.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PERF_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant: on conflict, the port not granted last wins.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = REQ_CORE;
        if (valid == 2'b11) begin
            if (last_grant == REQ_CORE) begin
                gnt    = 2'b10;
                gnt_id = REQ_DMA;
            end else begin
                gnt    = 2'b01;
                gnt_id = REQ_CORE;
            end
        end else if (valid[1]) begin
            gnt    = 2'b10;
            gnt_id = REQ_DMA;
        end else if (valid[0]) begin
            gnt    = 2'b01;
            gnt_id = REQ_CORE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for single-ported data_mem; DMEM_ARB_PERF_EN adds perf counters.
// Latency: accept in N, memory access in N, response valid from N+2; one outstanding.
// Backpressure: response held until the granted port's rsp_ready; no accepts meanwhile.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  DATA_W = DATA_W_DEF,
    localparam int BE_W   = DATA_W / 8
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic              c_req_we,
    input  logic [BE_W-1:0]   c_req_be,
    input  logic [DATA_W-1:0] c_req_wdata,
    output logic              c_rsp_valid,
    input  logic              c_rsp_ready,
    output logic [DATA_W-1:0] c_rsp_rdata,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [BE_W-1:0]   d_req_be,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_rdata,

`ifdef DMEM_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_core_grants,
    output logic [PERF_W-1:0] perf_dma_grants,
    output logic [PERF_W-1:0] perf_conflicts,
`endif

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    req_id_t           last_grant_q;
    req_id_t           gnt_id;
    req_id_t           gnt_id_q;
    logic [1:0]        req_valid;
    logic [1:0]        gnt;
    logic              arm_q;
    logic              accept;
    logic              we_q;
    logic              rsp_ready_sel;
    logic [DATA_W-1:0] rdata_q;

    assign req_valid = {d_req_valid, c_req_valid};

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    // arm_q keeps the accept path closed while reset is held, so ready and
    // mem_* read 0 during reset even with requests pending.
    assign accept = arm_q && (state_q == IDLE) && (|req_valid);

    assign c_req_ready = accept && gnt[0];
    assign d_req_ready = accept && gnt[1];

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (accept) begin
            if (gnt_id == REQ_DMA) begin
                mem_addr  = d_req_addr;
                mem_we    = d_req_we;
                mem_be    = d_req_be;
                mem_wdata = d_req_wdata;
            end else begin
                mem_addr  = c_req_addr;
                mem_we    = c_req_we;
                mem_be    = c_req_be;
                mem_wdata = c_req_wdata;
            end
        end
    end

    assign rsp_ready_sel = (gnt_id_q == REQ_DMA) ? d_rsp_ready : c_rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready_sel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_rsp_valid = (state_q == RESP) && (gnt_id_q == REQ_CORE);
        d_rsp_valid = (state_q == RESP) && (gnt_id_q == REQ_DMA);
        c_rsp_rdata = c_rsp_valid ? rdata_q : '0;
        d_rsp_rdata = d_rsp_valid ? rdata_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            arm_q        <= 1'b0;
            last_grant_q <= REQ_DMA;
            gnt_id_q     <= REQ_CORE;
            we_q         <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            if (accept) begin
                last_grant_q <= gnt_id;
                gnt_id_q     <= gnt_id;
                we_q         <= mem_we;
            end
            // Writes ack with zero data rather than whatever the memory returns.
            if (state_q == WAIT) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic conflict;

    assign conflict = arm_q && (state_q == IDLE) && (&req_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_core_grants <= '0;
            perf_dma_grants  <= '0;
            perf_conflicts   <= '0;
        end else if (perf_clr) begin
            perf_core_grants <= '0;
            perf_dma_grants  <= '0;
            perf_conflicts   <= '0;
        end else begin
            if (accept && (gnt_id == REQ_CORE)) perf_core_grants <= sat_inc(perf_core_grants);
            if (accept && (gnt_id == REQ_DMA))  perf_dma_grants  <= sat_inc(perf_dma_grants);
            if (conflict)                       perf_conflicts   <= sat_inc(perf_conflicts);
        end
    end
`endif

endmodule
